// File: rtl/stall_mem_resp.sv
// ============================================================================
// Module   : stall_mem_resp
// Brief    : 256x16 word memory responder that stalls the requester for a
//            fixed 4-cycle miss latency. Defining STALL_MEM_RESP_CACHE_EN adds
//            a 4-line direct-mapped read buffer serving same-cycle hits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stall_mem_resp (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    input  logic        createdump,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_BUSY      = 2'd1;
    localparam logic [1:0] c_CMPL      = 2'd2;
    localparam logic [2:0] c_MISS_WAIT = 3'd2;

    logic [1:0]  r_state;
    logic [2:0]  r_cnt;
    logic [7:0]  r_idx;
    logic [15:0] r_data;
    logic        r_is_wr;
    logic [15:0] r_mem [0:255];

    logic        w_legal;
    logic        w_illegal;
    logic        w_hit;
    logic        w_rd_hit;
    logic [15:0] w_line;
    logic        w_unused;

    // Upper address bits alias onto the 256-word array.
    assign w_unused  = &{1'b0, createdump, Addr[15:9]};
    assign w_legal   = (Rd ^ Wr) & ~Addr[0];
    assign w_illegal = (Rd | Wr) & ~w_legal;
    assign w_rd_hit  = w_legal & Rd & w_hit;

`ifdef STALL_MEM_RESP_CACHE_EN
    logic [3:0]  r_vld;
    logic [5:0]  r_tag  [0:3];
    logic [15:0] r_line [0:3];

    assign w_hit  = r_vld[Addr[2:1]] & (r_tag[Addr[2:1]] == Addr[8:3]);
    assign w_line = r_line[Addr[2:1]];

    // Reads allocate on completion; writes only refresh a line already holding the word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld <= '0;
        end else if (r_state == c_CMPL) begin
            if (!r_is_wr) begin
                r_vld[r_idx[1:0]]  <= 1'b1;
                r_tag[r_idx[1:0]]  <= r_idx[7:2];
                r_line[r_idx[1:0]] <= r_mem[r_idx];
            end else if (r_vld[r_idx[1:0]] && (r_tag[r_idx[1:0]] == r_idx[7:2])) begin
                r_line[r_idx[1:0]] <= r_data;
            end
        end
    end
`else
    assign w_hit  = 1'b0;
    assign w_line = 16'h0000;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 3'd0;
            r_idx   <= 8'd0;
            r_data  <= 16'h0000;
            r_is_wr <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_legal && !w_rd_hit) begin
                        r_idx   <= Addr[8:1];
                        r_data  <= DataIn;
                        r_is_wr <= Wr;
                        r_cnt   <= c_MISS_WAIT;
                        r_state <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= c_CMPL;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                c_CMPL:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst && (r_state == c_CMPL) && r_is_wr) begin
            r_mem[r_idx] <= r_data;
        end
    end

    always_comb begin
        DataOut  = 16'h0000;
        Done     = 1'b0;
        Stall    = 1'b0;
        CacheHit = 1'b0;
        err      = 1'b0;
        if (rst) begin
            case (r_state)
                c_IDLE: begin
                    if (w_illegal) begin
                        err = 1'b1;
                    end else if (w_rd_hit) begin
                        Done     = 1'b1;
                        CacheHit = 1'b1;
                        DataOut  = w_line;
                    end else if (w_legal) begin
                        Stall = 1'b1;
                    end
                end
                c_BUSY: Stall = 1'b1;
                c_CMPL: begin
                    Done = 1'b1;
                    if (!r_is_wr) begin
                        DataOut = r_mem[r_idx];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stall_mem_resp.sv
// ============================================================================
// Module   : tb_stall_mem_resp
// Brief    : Self-checking bench for stall_mem_resp (honours
//            STALL_MEM_RESP_CACHE_EN when defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stall_mem_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] Addr = 16'h0000;
    logic [15:0] DataIn = 16'h0000;
    logic        Rd = 1'b0;
    logic        Wr = 1'b0;
    logic        createdump = 1'b0;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        err;

`ifdef STALL_MEM_RESP_CACHE_EN
    localparam bit c_CACHE = 1'b1;
`else
    localparam bit c_CACHE = 1'b0;
`endif
    localparam int c_RD_LAT = c_CACHE ? 0 : 4;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stall_mem_resp dut (
        .clk        (clk),
        .rst        (rst),
        .Addr       (Addr),
        .DataIn     (DataIn),
        .Rd         (Rd),
        .Wr         (Wr),
        .createdump (createdump),
        .DataOut    (DataOut),
        .Done       (Done),
        .Stall      (Stall),
        .CacheHit   (CacheHit),
        .err        (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: word memory, line-buffer tags, and age of the in-flight access.
    logic [15:0] m_mem   [0:255];
    bit          m_known [0:255];
    bit          m_lv    [0:3];
    logic [5:0]  m_lt    [0:3];
    int          m_age = 0;
    logic [7:0]  m_idx;
    bit          m_wr;
    logic [15:0] m_d;

    function automatic bit m_hit(input logic [15:0] a);
        return c_CACHE && m_lv[a[2:1]] && (m_lt[a[2:1]] == a[8:3]);
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_age = 0;
            for (int i = 0; i < 4; i++) m_lv[i] = 1'b0;
        end else if (m_age == 0) begin
            if ((Rd ^ Wr) && !Addr[0] && !(Rd && m_hit(Addr))) begin
                m_age = 1;
                m_idx = Addr[8:1];
                m_wr  = Wr;
                m_d   = DataIn;
            end
        end else if (m_age < 4) begin
            m_age++;
        end else begin
            if (m_wr) begin
                m_mem[m_idx]   = m_d;
                m_known[m_idx] = 1'b1;
            end else begin
                m_lv[m_idx[1:0]] = 1'b1;
                m_lt[m_idx[1:0]] = m_idx[7:2];
            end
            m_age = 0;
        end
    end

    // Packed as {DataOut, Done, Stall, CacheHit, err}.
    always @(negedge clk) begin : p_cmp
        logic [19:0] e;
        logic [19:0] a;
        logic [19:0] msk;
        logic [7:0]  ri;
        bit          leg;
        bit          ill;
        e   = '0;
        msk = '1;
        if (rst) begin
            if (m_age == 0) begin
                leg = (Rd ^ Wr) && !Addr[0];
                ill = (Rd || Wr) && !leg;
                if (ill) begin
                    e[0] = 1'b1;
                end else if (leg && Rd && m_hit(Addr)) begin
                    ri        = Addr[8:1];
                    e[3]      = 1'b1;
                    e[1]      = 1'b1;
                    e[19:4]   = m_mem[ri];
                    if (!m_known[ri]) msk[19:4] = '0;
                end else if (leg) begin
                    e[2] = 1'b1;
                end
            end else if (m_age < 4) begin
                e[2] = 1'b1;
            end else begin
                e[3] = 1'b1;
                if (!m_wr) begin
                    e[19:4] = m_mem[m_idx];
                    if (!m_known[m_idx]) msk[19:4] = '0;
                end
            end
        end
        a = {DataOut, Done, Stall, CacheHit, err};
        chk("cycle", {12'h0, a & msk}, {12'h0, e & msk});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                       output int dcyc, output int nst, output bit hit, output logic [15:0] dout);
        dcyc = -1;
        nst  = 0;
        hit  = 1'b0;
        dout = 16'h0000;
        tick();
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (Stall) nst++;
            if (Done) begin
                dcyc = c;
                hit  = CacheHit;
                dout = DataOut;
                break;
            end
            tick();
        end
        tick();
        Rd = 1'b0; Wr = 1'b0;
    endtask

    task automatic xact(input string nm, input bit rd, input bit wr, input logic [15:0] a,
                        input logic [15:0] d, input int e_cyc, input bit e_hit, input logic [15:0] e_dout);
        int          dc;
        int          ns;
        bit          h;
        logic [15:0] dout;
        req(rd, wr, a, d, dc, ns, h, dout);
        chk({nm, "_lat"},   dc,   e_cyc);
        chk({nm, "_stall"}, ns,   e_cyc);
        chk({nm, "_hit"},   {31'h0, h}, {31'h0, e_hit});
        chk({nm, "_data"},  {16'h0, dout}, {16'h0, e_dout});
    endtask

    initial begin : p_watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_main
        int nd;
        tick();
        Rd = 1'b1; Addr = 16'h0011;
        @(negedge clk);
        chk("reset_outputs", {DataOut, Done, Stall, CacheHit, err}, 20'h0);
        tick();
        Rd = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("idle_outputs", {DataOut, Done, Stall, CacheHit, err}, 20'h0);

        xact("wr_beef",  1'b0, 1'b1, 16'h0010, 16'hBEEF, 4, 1'b0, 16'h0000);
        xact("rd_beef",  1'b1, 1'b0, 16'h0010, 16'h0000, 4, 1'b0, 16'hBEEF);
        xact("reread",   1'b1, 1'b0, 16'h0010, 16'h0000, c_RD_LAT, c_CACHE, 16'hBEEF);

        tick();
        Rd = 1'b1; Addr = 16'h0011;
        @(negedge clk);
        chk("err_odd",  {29'h0, err, Stall, Done}, 32'h4);
        tick();
        Wr = 1'b1; Addr = 16'h0010;
        @(negedge clk);
        chk("err_rdwr", {29'h0, err, Stall, Done}, 32'h4);
        tick();
        Rd = 1'b0; Wr = 1'b0;
        @(negedge clk);
        chk("idle_after_err", {29'h0, err, Stall, Done}, 32'h0);

        xact("wr_5a5a",       1'b0, 1'b1, 16'h0020, 16'h5A5A, 4, 1'b0, 16'h0000);
        xact("rd_after_wmiss", 1'b1, 1'b0, 16'h0010, 16'h0000, c_RD_LAT, c_CACHE, 16'hBEEF);

        tick();
        Wr = 1'b1; Addr = 16'h0020; DataIn = 16'h1234;
        @(negedge clk);
        chk("abort_c0", {31'h0, Stall}, 32'h1);
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_rst", {DataOut, Done, Stall, CacheHit, err}, 20'h0);
        tick();
        rst = 1'b1; Wr = 1'b0;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (Done) nd++;
            tick();
        end
        chk("abort_no_done", nd, 0);

        xact("rd_after_rst",  1'b1, 1'b0, 16'h0010, 16'h0000, 4, 1'b0, 16'hBEEF);
        xact("rd_0020_kept",  1'b1, 1'b0, 16'h0020, 16'h0000, 4, 1'b0, 16'h5A5A);
        xact("wr_0002",       1'b0, 1'b1, 16'h0002, 16'h1111, 4, 1'b0, 16'h0000);
        xact("wr_000a",       1'b0, 1'b1, 16'h000A, 16'h2222, 4, 1'b0, 16'h0000);
        xact("rd_0002",       1'b1, 1'b0, 16'h0002, 16'h0000, 4, 1'b0, 16'h1111);
        xact("rd_000a",       1'b1, 1'b0, 16'h000A, 16'h0000, 4, 1'b0, 16'h2222);
        xact("rd_000a_hit",   1'b1, 1'b0, 16'h000A, 16'h0000, c_RD_LAT, c_CACHE, 16'h2222);
        xact("rd_0002_evict", 1'b1, 1'b0, 16'h0002, 16'h0000, 4, 1'b0, 16'h1111);
        xact("rd_000a_fill",  1'b1, 1'b0, 16'h000A, 16'h0000, 4, 1'b0, 16'h2222);
        xact("wr_000a_wt",    1'b0, 1'b1, 16'h000A, 16'h3333, 4, 1'b0, 16'h0000);
        xact("rd_000a_wt",    1'b1, 1'b0, 16'h000A, 16'h0000, c_RD_LAT, c_CACHE, 16'h3333);
        xact("rd_alias",      1'b1, 1'b0, 16'h8010, 16'h0000, 4, 1'b0, 16'hBEEF);

        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
